// File: rtl/seg7_msg_scheduler.sv
// seg7_msg_scheduler: round-robin sharing of an 8-digit multiplexed
// seven-segment display between N_REQ frame sources, with built-in scan.
// Ports: clk, rst_n (async, active low); req_valid/req_ready/req_data
// per-source frame handshake; abcdefgh + digit drive the display pins;
// busy is high in SHOW/GAP; grant_id is the last granted source.
module seg7_msg_scheduler #(
  parameter int N_REQ       = 2,
  parameter int W_DIGIT     = 8,
  parameter int SCAN_DIV    = 4096,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W_DIGIT*8-1:0] req_data,
  output logic [7:0]                 abcdefgh,
  output logic [W_DIGIT-1:0]         digit,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int FW  = W_DIGIT * 8;
  localparam int IDW = $clog2(N_REQ);
  localparam int DW  = (W_DIGIT > 1) ? $clog2(W_DIGIT) : 1;
  localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, SHOW, GAP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr, rr_nx;
  logic [IDW-1:0] gid_nx;
  logic [FW-1:0]  fbuf, fbuf_nx;
  logic [SW-1:0]  scan_cnt, scan_cnt_nx;
  logic [DW-1:0]  scan_idx, scan_idx_nx;
  logic [HW-1:0]  hold_cnt, hold_nx;
  logic [GW-1:0]  gap_cnt, gap_nx;
  logic [7:0]     seg_nx;
  logic [W_DIGIT-1:0] digit_nx;

  logic           found;
  logic [IDW-1:0] sel;
  logic           gvalid;
  logic [FW-1:0]  gframe;
  logic [7:0]     lane;
  int             p;

  assign busy = (state == SHOW) || (state == GAP);

  always_comb begin
    req_ready = '0;
    if (state == GRANT)
      for (int i = 0; i < N_REQ; i++)
        if (IDW'(i) == grant_id) req_ready[i] = 1'b1;
  end

  always_comb begin
    // free-running digit scan
    scan_cnt_nx = scan_cnt + 1'b1;
    scan_idx_nx = scan_idx;
    if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt_nx = '0;
      scan_idx_nx = (scan_idx == DW'(W_DIGIT - 1)) ? '0
                                                   : scan_idx + 1'b1;
    end

    // first valid source at or after the rr pointer, wrapping
    found = 1'b0;
    sel   = '0;
    p     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      p = int'(rr) + k;
      if (p >= N_REQ) p = p - N_REQ;
      if (!found && req_valid[p]) begin
        found = 1'b1;
        sel   = IDW'(p);
      end
    end

    gvalid = 1'b0;
    gframe = '0;
    for (int i = 0; i < N_REQ; i++)
      if (IDW'(i) == grant_id) begin
        gvalid = req_valid[i];
        gframe = req_data[i*FW +: FW];
      end

    state_nx = state;
    rr_nx    = rr;
    gid_nx   = grant_id;
    fbuf_nx  = fbuf;
    hold_nx  = hold_cnt;
    gap_nx   = gap_cnt;

    unique case (state)
      IDLE: if (found) begin
        gid_nx   = sel;
        state_nx = GRANT;
      end
      GRANT: if (gvalid) begin
        fbuf_nx  = gframe;
        rr_nx    = (grant_id == IDW'(N_REQ - 1)) ? '0
                                                 : grant_id + 1'b1;
        hold_nx  = '0;
        state_nx = SHOW;
      end else begin
        state_nx = IDLE;
      end
      SHOW: if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
        gap_nx   = '0;
        state_nx = GAP;
      end else begin
        hold_nx = hold_cnt + 1'b1;
      end
      GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
        state_nx = IDLE;
      end else begin
        gap_nx = gap_cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // outputs are registered from next-state values so a captured
    // frame is visible on the first SHOW cycle
    lane = '0;
    for (int j = 0; j < W_DIGIT; j++)
      if (DW'(j) == scan_idx_nx) lane = fbuf_nx[j*8 +: 8];
    seg_nx   = (state_nx == SHOW) ? lane : 8'h00;
    digit_nx = W_DIGIT'(1) << scan_idx_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= '0;
      grant_id <= '0;
      fbuf     <= '0;
      scan_cnt <= '0;
      scan_idx <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      abcdefgh <= '0;
      digit    <= W_DIGIT'(1);
    end else begin
      state    <= state_nx;
      rr       <= rr_nx;
      grant_id <= gid_nx;
      fbuf     <= fbuf_nx;
      scan_cnt <= scan_cnt_nx;
      scan_idx <= scan_idx_nx;
      hold_cnt <= hold_nx;
      gap_cnt  <= gap_nx;
      abcdefgh <= seg_nx;
      digit    <= digit_nx;
    end
  end

endmodule

// File: tb/tb_seg7_msg_scheduler.sv
// tb_seg7_msg_scheduler: directed bench with a grant scoreboard
// for the seven-segment message scheduler.
module tb_seg7_msg_scheduler;

  localparam int N_REQ    = 2;
  localparam int W_DIGIT  = 8;
  localparam int SCAN_DIV = 4;
  localparam int HOLD     = 20;
  localparam int GAP      = 5;

  localparam logic [63:0] F0 = 64'h00000000_EEBCCE8E;
  localparam logic [63:0] F1 = 64'h7F077D6D_664F5B06;
  localparam logic [63:0] FX = 64'hDEADBEEF_A5A5A5A5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_data;
  logic [7:0]   abcdefgh;
  logic [7:0]   digit;
  logic         busy;
  logic [0:0]   grant_id;

  always #5 clk = ~clk;

  seg7_msg_scheduler #(
    .N_REQ(N_REQ), .W_DIGIT(W_DIGIT), .SCAN_DIV(SCAN_DIV),
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .abcdefgh(abcdefgh),
    .digit(digit), .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    int          id;
    logic [63:0] frame;
    bit          wd;
  } item_t;

  item_t       sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          scan_n = 0;
  int          rem = 0;
  int          n_grants = 0;
  int          g;
  logic [63:0] cur_frame = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    item_t       it;
    logic [63:0] eseg;
    int          idx;
    @(posedge clk);
    #1;
    scan_n++;
    idx = (scan_n / SCAN_DIV) % W_DIGIT;
    chk("digit", 64'(digit), 64'(1) << idx);
    if (rem > 0) begin
      chk("busy_hi", 64'(busy), 64'd1);
      chk("ready_quiet", 64'(req_ready), 64'd0);
      eseg = (rem > GAP) ? ((cur_frame >> (idx * 8)) & 64'hFF) : 64'd0;
      chk("seg_show", 64'(abcdefgh), eseg);
      rem--;
    end else begin
      chk("busy_lo", 64'(busy), 64'd0);
      chk("seg_blank", 64'(abcdefgh), 64'd0);
      if (req_ready != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 64'(req_ready), 64'd0);
        end else begin
          it = sb.pop_front();
          chk("grant_id", 64'(grant_id), 64'(it.id));
          chk("ready_onehot", 64'(req_ready), 64'(1) << it.id);
          if (!it.wd) begin
            cur_frame = it.frame;
            rem = HOLD + GAP;
          end
          n_grants++;
        end
      end
    end
  endtask

  task automatic wait_grants(input int target, input int limit);
    for (int i = 0; i < limit && n_grants < target; i++) step();
    chk("grant_timeout", 64'(n_grants >= target), 64'd1);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && rem > 0; i++) step();
    chk("idle_timeout", 64'(rem == 0), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digit", 64'(digit), 64'd1);
    chk("rst_seg", 64'(abcdefgh), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    rst_n = 1'b1;
    scan_n = 0;

    // idle scan: digit walks 01..80 and wraps, 4 cycles each
    repeat (36) step();

    // single grant of source 0
    req_data[63:0] = F0;
    req_valid = 2'b01;
    sb.push_back('{id: 0, frame: F0, wd: 1'b0});
    g = n_grants;
    step();
    chk("ready_latency", 64'(n_grants), 64'(g + 1));
    step();
    req_valid = 2'b00;
    wait_idle(40);
    repeat (2) step();

    // reset in the middle of SHOW for source 1
    req_data[127:64] = F1;
    req_valid = 2'b10;
    sb.push_back('{id: 1, frame: F1, wd: 1'b0});
    g = n_grants;
    wait_grants(g + 1, 10);
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 8 && digit == 8'h01; i++) step();
    chk("pre_rst_seg_live", 64'(abcdefgh != 8'h00), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_digit", 64'(digit), 64'd1);
    chk("arst_seg", 64'(abcdefgh), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd0);
    chk("arst_gid", 64'(grant_id), 64'd0);
    sb.delete();
    rem = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    scan_n = 0;
    step();

    // round robin with both sources valid: 0, 1, 0
    req_data[63:0] = F0;
    req_data[127:64] = F1;
    req_valid = 2'b11;
    sb.push_back('{id: 0, frame: F0, wd: 1'b0});
    sb.push_back('{id: 1, frame: F1, wd: 1'b0});
    sb.push_back('{id: 0, frame: F0, wd: 1'b0});
    g = n_grants;
    wait_grants(g + 3, 200);
    step();
    req_valid = 2'b00;
    wait_idle(40);
    repeat (2) step();

    // source 1 withdraws during GRANT
    req_valid = 2'b10;
    sb.push_back('{id: 1, frame: 64'd0, wd: 1'b1});
    g = n_grants;
    step();
    chk("wd_ready", 64'(n_grants), 64'(g + 1));
    req_valid = 2'b00;
    repeat (4) step();

    // pointer still at 1, so 1 goes before 0
    req_valid = 2'b11;
    sb.push_back('{id: 1, frame: F1, wd: 1'b0});
    sb.push_back('{id: 0, frame: F0, wd: 1'b0});
    g = n_grants;
    wait_grants(g + 1, 10);
    step();
    req_valid = 2'b01;
    wait_grants(g + 2, 60);
    step();
    req_valid = 2'b00;
    req_data[63:0] = FX;

    // late request from source 1 while 0 is showing
    repeat (8) step();
    req_valid = 2'b10;
    sb.push_back('{id: 1, frame: F1, wd: 1'b0});
    g = n_grants;
    wait_idle(40);
    step();
    chk("late_idle_ready", 64'(req_ready), 64'd0);
    step();
    chk("late_grant", 64'(n_grants), 64'(g + 1));
    chk("late_ready1", 64'(req_ready), 64'd2);
    step();
    req_valid = 2'b00;
    wait_idle(40);
    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
